// File: rtl/fetch_queue_if.sv
// Fetch-side bus: PC/Stall handshake with the PC register, instruction-memory
// req/ack read port, and the decoded-instruction head toward decode.
interface fetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] PC;
  logic          Stall;
  logic          Flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          IR_valid;
  logic [DW-1:0] IR;
  logic [AW-1:0] IR_PC;
  logic          IR_ready;

  modport master (
    input  PC, Flush, imem_ack, imem_rdata, IR_ready,
    output Stall, imem_req, imem_addr, IR_valid, IR, IR_PC
  );

  modport slave (
    output PC, Flush, imem_ack, imem_rdata, IR_ready,
    input  Stall, imem_req, imem_addr, IR_valid, IR, IR_PC
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: samples PC, runs one req/ack imem read at a time and
// buffers {PC, instruction} pairs for decode; Flush drops queued and in-flight work.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } entry_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  entry_t        fifo_q [DEPTH];

  logic not_full, issue, ack, push, pop, head_vld;

  always_comb begin
    not_full = (count_q < CW'(DEPTH));
    head_vld = (count_q != '0);
    issue    = (state_q == IDLE) && not_full && !bus.Flush;
    // Ack only counts while a request is actually on the bus.
    ack      = bus.imem_ack && req_q;
    push     = (state_q == WAIT) && ack && !bus.Flush;
    pop      = head_vld && bus.IR_ready && !bus.Flush;

    state_d  = state_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      IDLE: if (issue) begin
        state_d = WAIT;
        addr_d  = bus.PC;
      end
      WAIT: if (ack)            state_d = IDLE;
            else if (bus.Flush) state_d = DROP;
      DROP: if (ack)            state_d = IDLE;
      default:                  state_d = IDLE;
    endcase

    if (bus.Flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    req_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
    end
  end

  // Storage needs no reset: the head is gated by count.
  always_ff @(posedge Clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: addr_q, ins: bus.imem_rdata};
  end

  always_comb begin
    bus.imem_req  = req_q;
    bus.imem_addr = addr_q;
    bus.Stall     = bus.Flush ? 1'b0 : !((state_q == IDLE) && not_full);
    bus.IR_valid  = head_vld;
    bus.IR        = head_vld ? fifo_q[rd_ptr_q].ins : '0;
    bus.IR_PC     = head_vld ? fifo_q[rd_ptr_q].pc  : '0;
  end
endmodule
